vdp_vram_ctrl: RTL and testbench

VDP_VRAM_CTRL -- requirements
Module: vdp_vram_ctrl

---
 rtl/vdp_vram_ctrl_pkg.sv | 17 +
 rtl/vdp_vram_portb_arb.sv | 53 +++++
 rtl/vdp_vram_ctrl.sv | 159 +++++++++++++++
 tb/tb_vdp_vram_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_vram_ctrl_pkg.sv
// Shared VDP definitions: VRAM geometry, port-B read owners and the
// two-bit control-byte codes used by the host control port.
package vdp_vram_ctrl_pkg;

    localparam int VRAM_ADDR_W = 12;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    localparam logic [1:0] SET_RD = 2'b00;
    localparam logic [1:0] SET_WR = 2'b01;
    localparam logic [1:0] REG_WR = 2'b10;

endpackage

// File: rtl/vdp_vram_portb_arb.sv
// VRAM read-port arbiter: display fetches always win, the host read-ahead
// waits, and the owner of each issued read steers the returning byte.
module vdp_vram_portb_arb
    import vdp_vram_ctrl_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              cpu_pend,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        ram_rdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              cpu_grant,
    output logic              cpu_load,
    output logic              vid_ack,
    output logic [7:0]        vid_data
);

    owner_e owner_q, owner_d;

    // Nothing issues while reset is held, so the read address reads as zero.
    always_comb begin
        owner_d   = OWN_NONE;
        ram_raddr = '0;
        cpu_grant = 1'b0;
        if (rst_n) begin
            if (vid_req) begin
                owner_d   = OWN_VID;
                ram_raddr = vid_addr;
            end else if (cpu_pend) begin
                owner_d   = OWN_CPU;
                ram_raddr = cpu_addr;
                cpu_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign vid_ack  = (owner_q == OWN_VID);
    assign vid_data = vid_ack ? ram_rdata : 8'h00;
    assign cpu_load = (owner_q == OWN_CPU);

endmodule

// File: rtl/vdp_vram_ctrl.sv
// Host-side VRAM/register access for the VDP: two-byte control port,
// auto-incrementing data port with read-ahead buffer, shared read port.
module vdp_vram_ctrl
    import vdp_vram_ctrl_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_sel,
    input  logic              cpu_wr,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_busy,
    output logic              reg_we,
    output logic [2:0]        reg_addr,
    output logic [7:0]        reg_data,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [7:0]        ram_rdata
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              flip_q, flip_d;
    logic [7:0]        latch_q, latch_d;
    logic [7:0]        buf_q, buf_d;
    logic              pend_q, pend_d;
    logic [7:0]        dout_q, dout_d;
    logic              regwe_q, regwe_d;
    logic [2:0]        regaddr_q, regaddr_d;
    logic [7:0]        regdata_q, regdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cpu_grant, cpu_load, accept;
    logic [ADDR_W-1:0] ptr_set, ptr_inc;

    vdp_vram_portb_arb #(.ADDR_W(ADDR_W)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .cpu_pend  (pend_q),
        .cpu_addr  (ptr_q),
        .ram_rdata (ram_rdata),
        .ram_raddr (ram_raddr),
        .cpu_grant (cpu_grant),
        .cpu_load  (cpu_load),
        .vid_ack   (vid_ack),
        .vid_data  (vid_data)
    );

    assign cpu_busy = pend_q | cpu_load;
    assign accept   = cpu_sel & ~cpu_busy;
    assign ptr_set  = ADDR_W'({cpu_din[3:0], latch_q});
    assign ptr_inc  = ptr_q + ADDR_W'(1);

    always_comb begin
        ptr_d     = ptr_q;
        flip_d    = flip_q;
        latch_d   = latch_q;
        buf_d     = buf_q;
        pend_d    = pend_q;
        dout_d    = dout_q;
        regwe_d   = 1'b0;
        regaddr_d = regaddr_q;
        regdata_d = regdata_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (cpu_grant) pend_d = 1'b0;
        if (cpu_load)  buf_d  = ram_rdata;
        // Host strobes are only taken while no read-ahead is outstanding.
        if (accept) begin
            if (cpu_mode) begin
                if (!cpu_wr) begin
                    dout_d = 8'h00;
                    flip_d = 1'b0;
                end else if (!flip_q) begin
                    latch_d    = cpu_din;
                    flip_d     = 1'b1;
                    ptr_d[7:0] = cpu_din;
                end else begin
                    flip_d = 1'b0;
                    case (cpu_din[7:6])
                        SET_RD: begin
                            ptr_d  = ptr_set;
                            pend_d = 1'b1;
                        end
                        SET_WR: ptr_d = ptr_set;
                        REG_WR, 2'b11: begin
                            regwe_d   = 1'b1;
                            regaddr_d = cpu_din[2:0];
                            regdata_d = latch_q;
                        end
                    endcase
                end
            end else begin
                flip_d = 1'b0;
                ptr_d  = ptr_inc;
                if (cpu_wr) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = cpu_din;
                    buf_d   = cpu_din;
                end else begin
                    dout_d = buf_q;
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            flip_q    <= 1'b0;
            latch_q   <= 8'h00;
            buf_q     <= 8'h00;
            pend_q    <= 1'b0;
            dout_q    <= 8'h00;
            regwe_q   <= 1'b0;
            regaddr_q <= 3'd0;
            regdata_q <= 8'h00;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 8'h00;
        end else begin
            ptr_q     <= ptr_d;
            flip_q    <= flip_d;
            latch_q   <= latch_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            dout_q    <= dout_d;
            regwe_q   <= regwe_d;
            regaddr_q <= regaddr_d;
            regdata_q <= regdata_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign cpu_dout  = dout_q;
    assign reg_we    = regwe_q;
    assign reg_addr  = regaddr_q;
    assign reg_data  = regdata_q;
    assign ram_we    = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_vdp_vram_ctrl.sv
// Scoreboard bench for vdp_vram_ctrl: stimulus pushes expected RAM writes,
// register writes, display fetches and host reads; a monitor pops them.
module tb_vdp_vram_ctrl;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_sel, cpu_wr, cpu_mode;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_busy, reg_we;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic        ram_we;
    logic [11:0] ram_waddr, ram_raddr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  mem [0:4095];
    exp_t        wrQ[$], regQ[$], vidQ[$], rdQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic        rdPend = 1'b0;

    vdp_vram_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_mode(cpu_mode),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic popCheck(input string name, inout exp_t q[$], input logic [11:0] addr, input logic [7:0] data);
        exp_t e;
        if (q.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: unexpected output addr %h data %h, nothing expected", name, addr, data);
        end else begin
            e = q.pop_front();
            checkOutput(name, {44'd0, addr, data}, {44'd0, e.addr, e.data});
        end
    endtask

    // Monitor: compare every presented output against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we)  popCheck("ramWrite", wrQ, ram_waddr, ram_wdata);
            if (reg_we)  popCheck("regWrite", regQ, {9'd0, reg_addr}, reg_data);
            if (vid_ack) popCheck("vidFetch", vidQ, 12'd0, vid_data);
            if (rdPend)  popCheck("hostRead", rdQ, 12'd0, cpu_dout);
            rdPend = cpu_sel && !cpu_wr && !cpu_busy;
        end else begin
            rdPend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mode, input logic wr, input logic [7:0] din);
        cpu_sel  = 1'b1;
        cpu_mode = mode;
        cpu_wr   = wr;
        cpu_din  = din;
        tick();
        cpu_sel  = 1'b0;
    endtask

    task automatic waitNotBusy(input string name);
        int n = 0;
        while (cpu_busy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: cpu_busy still 1 after %0d cycles, expected 0", name, n);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic logic [63:0] allOutputs();
        return {1'b0, cpu_dout, cpu_busy, reg_we, reg_addr, reg_data, vid_ack, vid_data,
                ram_we, ram_waddr, ram_wdata, ram_raddr};
    endfunction

    initial begin
        rst_n    = 1'b0;
        cpu_sel  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_mode = 1'b0;
        cpu_din  = 8'h00;
        vid_req  = 1'b0;
        vid_addr = 12'h000;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 10; i++) mem[i] = 8'h60 + 8'(i);
        mem[12'h380] = 8'h17;
        mem[12'h381] = 8'h4A;
        mem[12'h800] = 8'h9C;
        mem[12'hA00] = 8'hE7;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOutputs", allOutputs(), 64'd0);
        checkOutput("resetPointer", {52'd0, dut.ptr_q}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Write address 0x334, two data writes.
        applyStimulus(1'b1, 1'b1, 8'h34);
        applyStimulus(1'b1, 1'b1, 8'h43);
        wrQ.push_back(mk(12'h334, 8'hAA));
        applyStimulus(1'b0, 1'b1, 8'hAA);
        wrQ.push_back(mk(12'h335, 8'hBB));
        applyStimulus(1'b0, 1'b1, 8'hBB);
        checkOutput("ptrAfterWrites", {52'd0, dut.ptr_q}, 64'h336);

        // Read address 0x380 with read-ahead, two data reads.
        applyStimulus(1'b1, 1'b1, 8'h80);
        applyStimulus(1'b1, 1'b1, 8'h03);
        checkOutput("busyAfterSetRd", {63'd0, cpu_busy}, 64'd1);
        waitNotBusy("readAhead380");
        rdQ.push_back(mk(12'h000, 8'h17));
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitNotBusy("readAhead381");
        rdQ.push_back(mk(12'h000, 8'h4A));
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitNotBusy("readAhead382");

        // Register write: R7 <= 0xF5; only the low pointer byte moves.
        regQ.push_back(mk(12'h007, 8'hF5));
        applyStimulus(1'b1, 1'b1, 8'hF5);
        applyStimulus(1'b1, 1'b1, 8'h87);
        checkOutput("ptrAfterRegWr", {52'd0, dut.ptr_q}, 64'h3F5);

        // Read-ahead starved by ten display fetches, with an ignored strobe.
        applyStimulus(1'b1, 1'b1, 8'h00);
        cpu_sel  = 1'b1;
        cpu_din  = 8'h08;
        vid_req  = 1'b1;
        vid_addr = 12'h000;
        vidQ.push_back(mk(12'h000, 8'h60));
        tick();
        for (int i = 1; i < 10; i++) begin
            cpu_sel  = (i == 5);
            cpu_mode = 1'b0;
            cpu_din  = 8'hEE;
            vid_addr = 12'(i);
            vidQ.push_back(mk(12'h000, 8'h60 + 8'(i)));
            checkOutput("busyWhileStarved", {63'd0, cpu_busy}, 64'd1);
            tick();
        end
        cpu_sel = 1'b0;
        vid_req = 1'b0;
        tick();
        tick();
        checkOutput("bufferAfterStarve", {56'd0, dut.buf_q}, 64'h9C);
        checkOutput("busyAfterStarve", {63'd0, cpu_busy}, 64'd0);
        checkOutput("ptrIgnoredStrobe", {52'd0, dut.ptr_q}, 64'h800);
        rdQ.push_back(mk(12'h000, 8'h9C));
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitNotBusy("readAhead801");

        // Pointer wrap and flip-flop clear by control read.
        applyStimulus(1'b1, 1'b1, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'h4F);
        wrQ.push_back(mk(12'hFFF, 8'h55));
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkOutput("ptrWrap", {52'd0, dut.ptr_q}, 64'h000);
        applyStimulus(1'b1, 1'b1, 8'h12);
        rdQ.push_back(mk(12'h000, 8'h00));
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h40);
        checkOutput("ptrAfterFlipClear", {52'd0, dut.ptr_q}, 64'h000);
        wrQ.push_back(mk(12'h000, 8'h66));
        applyStimulus(1'b0, 1'b1, 8'h66);

        // Reset landing while a read-ahead is in flight.
        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h0A);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midReadResetOutputs", allOutputs(), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postResetOutputs", allOutputs(), 64'd0);
        checkOutput("postResetBuffer", {56'd0, dut.buf_q}, 64'h00);
        tick();

        checkOutput("queuesDrained", 64'(wrQ.size() + regQ.size() + vidQ.size() + rdQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
